// File: rtl/rf_multi.sv
// Multi-read-port register file with a priority write port, a write-back port and
// a per-register pending scoreboard. Reads are combinational; writes commit on clk.

module rf_multi_rd #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                          en,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [DEPTH-1:0]              pend,
  input  logic                          pc_act,
  input  logic [ADDR_W-1:0]             pc_addr,
  input  logic [DATA_W-1:0]             pc_data,
  input  logic                          w_act,
  input  logic [ADDR_W-1:0]             w_addr,
  input  logic [DATA_W-1:0]             w_data,
  output logic [DATA_W-1:0]             data,
  output logic                          busy
);
  logic r0_hit;
  assign r0_hit = (ZERO_R0 != 0) && (addr == '0);

  always_comb begin
    data = '0;
    if (en && !r0_hit) begin
      // Forwarding mirrors commit priority: pc overrides w-back.
      if ((BYPASS != 0) && pc_act && (pc_addr == addr))     data = pc_data;
      else if ((BYPASS != 0) && w_act && (w_addr == addr))  data = w_data;
      else                                                  data = mem[addr];
    end
  end

  // Pre-edge pending only; a same-cycle write-back does not clear busy early.
  assign busy = en && pend[addr] && !r0_hit;
endmodule

module rf_multi #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_en,
  input  logic [ADDR_W-1:0]      pc_addr,
  input  logic [DATA_W-1:0]      pc_data,
  input  logic                   w_en,
  input  logic [ADDR_W-1:0]      w_addr,
  input  logic [DATA_W-1:0]      w_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  output logic                   coll
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic                         coll_q, coll_d;
  logic                         pc_act, w_act, rsv_act;

  // Qualified enables: nothing lands while in reset or on a hardwired r0.
  assign pc_act  = pc_en  && rst_n && !((ZERO_R0 != 0) && (pc_addr  == '0));
  assign w_act   = w_en   && rst_n && !((ZERO_R0 != 0) && (w_addr   == '0));
  assign rsv_act = rsv_en && rst_n && !((ZERO_R0 != 0) && (rsv_addr == '0));

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    coll_d = pc_act && w_act && (pc_addr == w_addr);
    if (w_act)   mem_d[w_addr]    = w_data;
    if (pc_act)  mem_d[pc_addr]   = pc_data;
    if (w_act)   pend_d[w_addr]   = 1'b0;
    // A new reservation outranks a retiring write-back to the same register.
    if (rsv_act) pend_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      pend_q <= '0;
      coll_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      coll_q <= coll_d;
    end
  end

  assign coll = coll_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_multi_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
      .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rd (
      .en      (rd_en[k]),
      .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem     (mem_q),
      .pend    (pend_q),
      .pc_act  (pc_act),
      .pc_addr (pc_addr),
      .pc_data (pc_data),
      .w_act   (w_act),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .data    (rd_data[k*DATA_W +: DATA_W]),
      .busy    (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_rf_multi.sv
// Directed bench for rf_multi: default, no-bypass and zero-r0 instances share stimulus.

module tb_rf_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en, w_en, rsv_en;
  logic [3:0]  pc_addr, w_addr, rsv_addr;
  logic [15:0] pc_data, w_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rdd_a, rdd_b, rdd_z;
  logic [1:0]  busy_a, busy_b, busy_z;
  logic        coll_a, coll_b, coll_z;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  rf_multi u_a (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .pc_addr(pc_addr), .pc_data(pc_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_busy(busy_a), .coll(coll_a));

  rf_multi #(.BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .pc_addr(pc_addr), .pc_data(pc_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(busy_b), .coll(coll_b));

  rf_multi #(.ZERO_R0(1)) u_z (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .pc_addr(pc_addr), .pc_data(pc_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_z), .rd_busy(busy_z), .coll(coll_z));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_en = 0; w_en = 0; rsv_en = 0;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_en = 2'b11;
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 0; idle();
    pc_addr = 0; pc_data = 0; w_addr = 0; w_data = 0; rsv_addr = 0;
    rd(4'd0, 4'd1);
    #2;
    chk("rst_rd", rdd_a, 32'h0);
    chk("rst_busy", {30'd0, busy_a}, 32'h0);
    chk("rst_coll", {31'd0, coll_a}, 32'h0);
    step();
    rst_n = 1;
    step();

    // dual write to distinct addresses
    pc_en = 1; pc_addr = 3; pc_data = 16'h1111;
    w_en = 1;  w_addr = 5;  w_data = 16'h2222;
    step(); idle(); rd(4'd3, 4'd5); #1;
    chk("dual_rd", rdd_a, 32'h2222_1111);
    chk("dual_coll", {31'd0, coll_a}, 32'h0);

    // same-address collision
    pc_en = 1; pc_addr = 7; pc_data = 16'hAAAA;
    w_en = 1;  w_addr = 7;  w_data = 16'h5555;
    step(); idle(); rd(4'd7, 4'd7); #1;
    chk("coll_rd", rdd_a, 32'hAAAA_AAAA);
    chk("coll_pulse", {31'd0, coll_a}, 32'h1);
    step();
    chk("coll_drop", {31'd0, coll_a}, 32'h0);

    // bypass vs pre-edge value
    w_en = 1; w_addr = 2; w_data = 16'h1234;
    step(); idle();
    w_en = 1; w_addr = 2; w_data = 16'hBEEF; rd(4'd2, 4'd5); #1;
    chk("byp_on", {16'd0, rdd_a[15:0]}, 32'hBEEF);
    chk("byp_off", {16'd0, rdd_b[15:0]}, 32'h1234);
    step(); idle(); #1;
    chk("byp_commit_b", {16'd0, rdd_b[15:0]}, 32'hBEEF);
    pc_en = 1; pc_addr = 2; pc_data = 16'hCAFE;
    w_en = 1;  w_addr = 2;  w_data = 16'hBEEF; #1;
    chk("byp_pc_wins", {16'd0, rdd_a[15:0]}, 32'hCAFE);
    step(); idle();

    // scoreboard
    rsv_en = 1; rsv_addr = 4; rd(4'd2, 4'd4); #1;
    chk("rsv_pre", {30'd0, busy_a}, 32'h0);
    step(); idle(); #1;
    chk("rsv_busy", {30'd0, busy_a}, 32'h2);
    w_en = 1; w_addr = 4; w_data = 16'h4444; #1;
    chk("wb_busy_hold", {30'd0, busy_a}, 32'h2);
    chk("wb_byp", {16'd0, rdd_a[31:16]}, 32'h4444);
    step(); idle(); #1;
    chk("wb_clear", {30'd0, busy_a}, 32'h0);
    chk("wb_data", {16'd0, rdd_a[31:16]}, 32'h4444);
    rsv_en = 1; rsv_addr = 4; w_en = 1; w_addr = 4; w_data = 16'h4545;
    step(); idle(); #1;
    chk("rsv_w_same", {30'd0, busy_a}, 32'h2);
    pc_en = 1; pc_addr = 4; pc_data = 16'h4646;
    step(); idle(); #1;
    chk("pc_keeps_pend", {30'd0, busy_a}, 32'h2);
    chk("pc_data4", {16'd0, rdd_a[31:16]}, 32'h4646);

    // zero r0
    pc_en = 1; pc_addr = 0; pc_data = 16'hFFFF;
    w_en = 1;  w_addr = 0;  w_data = 16'hFFFF;
    rsv_en = 1; rsv_addr = 0; rd(4'd0, 4'd4); #1;
    chk("z_byp", {16'd0, rdd_z[15:0]}, 32'h0);
    chk("a_byp0", {16'd0, rdd_a[15:0]}, 32'hFFFF);
    step(); idle(); #1;
    chk("z_rd0", {16'd0, rdd_z[15:0]}, 32'h0);
    chk("z_busy0", {31'd0, busy_z[0]}, 32'h0);
    chk("z_coll", {31'd0, coll_z}, 32'h0);
    chk("a_coll0", {31'd0, coll_a}, 32'h1);
    chk("a_busy", {30'd0, busy_a}, 32'h3);
    chk("a_rd0", {16'd0, rdd_a[15:0]}, 32'hFFFF);

    // asynchronous reset between edges
    #2 rst_n = 0; #1;
    chk("ar_rd", rdd_a, 32'h0);
    chk("ar_busy", {30'd0, busy_a}, 32'h0);
    chk("ar_coll", {31'd0, coll_a}, 32'h0);
    w_en = 1; w_addr = 4; w_data = 16'h7777;
    rsv_en = 1; rsv_addr = 5; rd(4'd4, 4'd5); #1;
    chk("ar_no_byp", rdd_a, 32'h0);
    step();
    chk("ar_ignored", rdd_a, 32'h0);
    chk("ar_busy_hold", {30'd0, busy_a}, 32'h0);
    idle(); #2 rst_n = 1;
    step(); #1;
    chk("post_rd", rdd_a, 32'h0);
    w_en = 1; w_addr = 9; w_data = 16'h9999;
    step(); idle(); rd(4'd9, 4'd3); #1;
    chk("post_write", rdd_a, 32'h0000_9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end
endmodule
